// File: rtl/main_memory_responder.sv
// Memory-side responder for the cache-to-memory interface: fixed-latency block
// refill bursts and single-word write-through commits against a backing array.
module main_memory_responder #(
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned LATENCY         = 4,
  parameter int unsigned MEM_DEPTH       = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ready,
  output logic                  mem_rvalid,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wack
);

  localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
  localparam int unsigned BEAT_W  = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned CNT_W   = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_WDONE} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [WORD_AW-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  ready_q, ready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  wack_q, wack_d;

  logic                  mem_wr_c;
  logic [WORD_AW-1:0]    base_c;
  logic [BEAT_W-1:0]     beat_nxt_c;
  logic                  unused_offset_c;

  // Backing array starts zeroed and is deliberately outside the reset domain.
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH] = '{default: '0};

  assign unused_offset_c = ^mem_addr[1:0];
  assign base_c          = addr_q & ~WORD_AW'(WORDS_PER_BLOCK - 1);
  assign beat_nxt_c      = beat_q + BEAT_W'(1);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    ready_d  = ready_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    wack_d   = wack_q;
    mem_wr_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_req && ready_q) begin
          we_d    = mem_we;
          addr_d  = mem_addr[ADDR_WIDTH-1:2];
          wdata_d = mem_wdata;
          ready_d = 1'b0;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (we_q) begin
            mem_wr_c = 1'b1;
            wack_d   = 1'b1;
            state_d  = S_WDONE;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = mem_q[base_c];
            beat_d   = '0;
            state_d  = S_BURST;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_BURST: begin
        if (beat_q == BEAT_W'(WORDS_PER_BLOCK - 1)) begin
          rvalid_d = 1'b0;
          rdata_d  = '0;
          ready_d  = 1'b1;
          state_d  = S_IDLE;
        end else begin
          beat_d  = beat_nxt_c;
          rdata_d = mem_q[base_c | WORD_AW'(beat_nxt_c)];
        end
      end
      S_WDONE: begin
        wack_d  = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      wack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      wack_q   <= wack_d;
    end
  end

  // A reset on the commit edge drops the write along with the transaction.
  always_ff @(posedge clk) begin
    if (mem_wr_c && !rst) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign mem_ready  = ready_q;
  assign mem_rvalid = rvalid_q;
  assign mem_rdata  = rdata_q;
  assign mem_wack   = wack_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder (LATENCY=4, WORDS_PER_BLOCK=4).
module tb_main_memory_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_wack;

  int n_cmp = 0;
  int n_err = 0;

  main_memory_responder #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .WORDS_PER_BLOCK(4), .LATENCY(4), .MEM_DEPTH(256)
  ) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_wack(mem_wack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // exp holds beats {b3,b2,b1,b0}; poke fires an ignored write to 0x100 mid-burst.
  task automatic do_read(input logic [9:0] addr, input logic [127:0] exp, input bit poke);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = addr;
    tick();
    check("rd_accept_ready", 32'(mem_ready), 32'd0);
    mem_req = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("rd_wait_rvalid", 32'(mem_rvalid), 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rd_beat_rvalid", 32'(mem_rvalid), 32'd1);
      check("rd_beat_data", mem_rdata, exp[32*k +: 32]);
      check("rd_beat_wack", 32'(mem_wack), 32'd0);
      check("rd_beat_ready", 32'(mem_ready), 32'd0);
      if (poke && k == 0) begin
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 10'h100; mem_wdata = 32'h1234_5678;
      end else if (poke && k == 1) begin
        mem_req = 1'b0;
      end
    end
    tick();
    check("rd_end_rvalid", 32'(mem_rvalid), 32'd0);
    check("rd_end_rdata", mem_rdata, 32'd0);
    check("rd_end_ready", 32'(mem_ready), 32'd1);
    check("rd_end_wack", 32'(mem_wack), 32'd0);
  endtask

  task automatic do_write(input logic [9:0] addr, input logic [31:0] data);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = addr; mem_wdata = data;
    tick();
    check("wr_accept_ready", 32'(mem_ready), 32'd0);
    mem_req = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("wr_wait_wack", 32'(mem_wack), 32'd0);
    end
    tick();
    check("wr_commit_wack", 32'(mem_wack), 32'd1);
    check("wr_commit_ready", 32'(mem_ready), 32'd0);
    tick();
    check("wr_done_wack", 32'(mem_wack), 32'd0);
    check("wr_done_ready", 32'(mem_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    tick();
    tick();
    check("rst_ready", 32'(mem_ready), 32'd1);
    check("rst_rvalid", 32'(mem_rvalid), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_wack", 32'(mem_wack), 32'd0);
    rst = 1'b0;
    tick();

    // 1: read of zeroed array
    do_read(10'h000, 128'h0, 1'b0);

    // 2: write-through then read back
    do_write(10'h000, 32'h0000_00FF);
    do_read(10'h000, {32'h0, 32'h0, 32'h0, 32'h0000_00FF}, 1'b0);

    // 3: byte offset ignored, block base 0x200
    do_write(10'h204, 32'hDEAD_BEEF);
    do_read(10'h20E, {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0}, 1'b0);

    // 4: request during a burst is dropped
    do_read(10'h000, {32'h0, 32'h0, 32'h0, 32'h0000_00FF}, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("poke_no_wack", 32'(mem_wack), 32'd0);
    end
    do_read(10'h100, 128'h0, 1'b0);

    // 5a: reset after beat 2 of a read
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 10'h200;
    tick();
    mem_req = 1'b0;
    repeat (3) tick();
    tick();
    check("rstrd_beat0", mem_rdata, 32'h0);
    tick();
    check("rstrd_beat1", mem_rdata, 32'hDEAD_BEEF);
    tick();
    check("rstrd_beat2_valid", 32'(mem_rvalid), 32'd1);
    rst = 1'b1;
    tick();
    check("rstrd_rvalid", 32'(mem_rvalid), 32'd0);
    check("rstrd_ready", 32'(mem_ready), 32'd1);
    check("rstrd_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // 5b: reset while a write waits; the write is dropped
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 10'h008; mem_wdata = 32'h55;
    tick();
    mem_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rstwr_ready", 32'(mem_ready), 32'd1);
    check("rstwr_wack", 32'(mem_wack), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rstwr_no_wack", 32'(mem_wack), 32'd0);
    end
    do_read(10'h000, {32'h0, 32'h0, 32'h0, 32'h0000_00FF}, 1'b0);

    // reset wins over a simultaneous request
    rst = 1'b1; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 10'h000;
    tick();
    rst = 1'b0; mem_req = 1'b0;
    tick();
    check("rstreq_ready", 32'(mem_ready), 32'd1);
    check("rstreq_rvalid", 32'(mem_rvalid), 32'd0);

    // 6: held request, back-to-back read then write
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 10'h000;
    tick();
    check("b2b_t0_ready", 32'(mem_ready), 32'd0);
    mem_we = 1'b1; mem_addr = 10'h010; mem_wdata = 32'hA5A5_A5A5;
    for (int t = 1; t <= 7; t++) begin
      tick();
      check("b2b_rd_ready", 32'(mem_ready), 32'd0);
      check("b2b_rd_rvalid", 32'(mem_rvalid), (t >= 4) ? 32'd1 : 32'd0);
    end
    tick();
    check("b2b_t8_ready", 32'(mem_ready), 32'd1);
    check("b2b_t8_rvalid", 32'(mem_rvalid), 32'd0);
    tick();
    check("b2b_t9_accept", 32'(mem_ready), 32'd0);
    mem_req = 1'b0;
    for (int t = 10; t <= 12; t++) begin
      tick();
      check("b2b_wr_wait_wack", 32'(mem_wack), 32'd0);
    end
    tick();
    check("b2b_t13_wack", 32'(mem_wack), 32'd1);
    tick();
    check("b2b_t14_wack", 32'(mem_wack), 32'd0);
    check("b2b_t14_ready", 32'(mem_ready), 32'd1);
    do_read(10'h010, {32'h0, 32'h0, 32'h0, 32'hA5A5_A5A5}, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
